// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage
// 8-bit-PC / 9-bit-instruction core. Resolves taken branches, load-use
// hazards, multi-cycle EX occupancy and HALT, and drives the PC enable/select
// plus stall/flush/bubble controls for IF/ID, ID/EX and EX/MEM. Also keeps
// two saturating performance counters (frozen-PC cycles, branch redirects).
module hazard_ctrl #(
  parameter int REG_W = 3,
  parameter int MC_W  = 4
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_mc,
  input  logic [MC_W-1:0]  ex_mc_len,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             halted,
  output logic [15:0]      stall_cycles,
  output logic [7:0]       flush_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [MC_W-1:0] mc_cnt;
  logic [MC_W-1:0] mc_cnt_nxt;

  logic rs_hit;
  logic rt_hit;
  logic branch_ev;
  logic mc_ev;
  logic load_use_ev;
  logic halt_ev;
  logic flush_inc;
  logic stall_inc;

  // Hazard detection. Each event is qualified by the valid bit of the stage
  // it inspects, so bubbles in ID or EX never raise a hazard.
  assign rs_hit      = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit      = id_uses_rt && (id_rt == ex_rd);
  assign branch_ev   = ex_valid && ex_branch_taken;
  assign mc_ev       = ex_valid && ex_mc && (ex_mc_len >= MC_W'(2));
  assign load_use_ev = ex_valid && ex_mem_read && id_valid && (rs_hit || rt_hit);
  assign halt_ev     = id_valid && id_halt;

  // Control decode: outputs and next state from current state and events.
  // Everything is forced low while reset is held, even though the flops are
  // already cleared, so the pipeline sees a quiet controller during reset.
  always_comb begin
    // NOTE: every signal written here gets a default first; otherwise a path
    // that skips an assignment would infer a latch.
    state_nxt     = state;
    mc_cnt_nxt    = mc_cnt;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    halted        = 1'b0;
    flush_inc     = 1'b0;

    if (reset_n) begin
      case (state)
        RUN: begin
          pc_write = 1'b1;
          if (branch_ev) begin
            // Redirect wins over everything; a multi-cycle flag on the
            // branch itself is dropped because that instruction is squashed.
            pc_sel       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
          end else if (mc_ev) begin
            // First of L-1 stall cycles; mc_cnt holds the remaining L-2.
            pc_write      = 1'b0;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            mc_cnt_nxt    = ex_mc_len - MC_W'(2);
            state_nxt     = MC_BUSY;
          end else if (load_use_ev) begin
            // One stall; the bubble reaches EX next cycle and clears it.
            pc_write     = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (halt_ev) begin
            pc_write     = 1'b0;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = HALTED;
          end
        end

        MC_BUSY: begin
          if (mc_cnt != '0) begin
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            mc_cnt_nxt    = mc_cnt - MC_W'(1);
          end else begin
            // Release cycle: RUN defaults, other events are not looked at.
            pc_write  = 1'b1;
            state_nxt = RUN;
          end
        end

        HALTED: begin
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          halted       = 1'b1;
        end

        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // The halt-entry cycle counts as a stall; cycles spent in HALTED do not.
  assign stall_inc = reset_n && !pc_write && (state != HALTED);

  // State, multi-cycle down-counter and saturating performance counters.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      mc_cnt       <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
      if (stall_inc && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (flush_inc && (flush_count != 8'hFF)) begin
        flush_count <= flush_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized bench for hazard_ctrl. A
// behavioural model (halted flag, remaining multi-cycle occupancy, integer
// counters) is checked against every DUT output on each falling edge; a set
// of hand-computed literal expectations pins the directed scenarios.
module tb_hazard_ctrl;

  localparam int REG_W = 3;
  localparam int MC_W  = 4;

  logic             CLK = 1'b0;
  logic             reset_n;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_halt;
  logic             ex_valid;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             ex_mc;
  logic [MC_W-1:0]  ex_mc_len;
  logic             pc_write;
  logic             pc_sel;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_bubble;
  logic             ex_mem_bubble;
  logic             halted;
  logic [15:0]      stall_cycles;
  logic [7:0]       flush_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.REG_W(REG_W), .MC_W(MC_W)) dut (
    .CLK            (CLK),
    .reset_n        (reset_n),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_halt        (id_halt),
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .ex_mc          (ex_mc),
    .ex_mc_len      (ex_mc_len),
    .pc_write       (pc_write),
    .pc_sel         (pc_sel),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_stall    (id_ex_stall),
    .id_ex_bubble   (id_ex_bubble),
    .ex_mem_bubble  (ex_mem_bubble),
    .halted         (halted),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  // ---------------- behavioural model ----------------
  bit m_halted  = 0;
  int m_mc_left = 0;  // cycles still owned by a multi-cycle op (stalls + release)
  int m_stall   = 0;
  int m_flush   = 0;

  // Per-cycle check of all outputs against the model, then model advance.
  always @(negedge CLK) begin
    logic [7:0]  e_ctl;  // {pw, sel, ifs, iff, ids, idb, exb, halted}
    logic [31:0] exp_v;
    logic [31:0] act_v;
    bool_dummy: begin end
    e_ctl = 8'h00;
    if (!reset_n) begin
      m_halted = 0; m_mc_left = 0; m_stall = 0; m_flush = 0;
    end else if (m_halted) begin
      e_ctl = 8'b0010_0101;
    end else if (m_mc_left > 1) begin
      e_ctl = 8'b0010_1010;
    end else if (m_mc_left == 1) begin
      e_ctl = 8'b1000_0000;
    end else if (ex_valid && ex_branch_taken) begin
      e_ctl = 8'b1101_0100;
    end else if (ex_valid && ex_mc && ex_mc_len >= 2) begin
      e_ctl = 8'b0010_1010;
    end else if (ex_valid && ex_mem_read && id_valid &&
                 ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd))) begin
      e_ctl = 8'b0010_0100;
    end else if (id_valid && id_halt) begin
      e_ctl = 8'b0010_0100;
    end else begin
      e_ctl = 8'b1000_0000;
    end

    exp_v = {e_ctl, m_stall[15:0], m_flush[7:0]};
    act_v = {pc_write, pc_sel, if_id_stall, if_id_flush, id_ex_stall,
             id_ex_bubble, ex_mem_bubble, halted, stall_cycles, flush_count};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act_v, exp_v);
    end

    // Advance the model to what the next rising edge commits.
    if (reset_n) begin
      if (!e_ctl[7] && !m_halted && m_stall < 65535) m_stall++;
      if (e_ctl[6] && m_flush < 255) m_flush++;
      if (!m_halted) begin
        if (m_mc_left > 0) m_mc_left--;
        else if (ex_valid && ex_branch_taken) ;
        else if (ex_valid && ex_mc && ex_mc_len >= 2) m_mc_left = int'(ex_mc_len) - 1;
        else if (e_ctl == 8'b0010_0100 && !(ex_valid && ex_mem_read && id_valid &&
                 ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd))))
          m_halted = 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_halt = 0;
    ex_valid = 0; ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0; ex_mc = 0; ex_mc_len = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    settle();
    check("reset_pc_write", 32'(pc_write), 32'd0);
    check("reset_counters", {stall_cycles, flush_count}, 32'd0);
    tick();
    reset_n = 1;
  endtask

  // Issue one multi-cycle op of length len and count frozen-PC cycles.
  task automatic mc_run(input int len, output int stalls, output int exb);
    stalls = 0; exb = 0;
    idle();
    ex_valid = 1; ex_mc = 1; ex_mc_len = MC_W'(len);
    settle();
    if (!pc_write) stalls++;
    if (ex_mem_bubble) exb++;
    tick();
    idle();
    for (int i = 0; i < 20; i++) begin
      settle();
      if (!pc_write) stalls++;
      if (ex_mem_bubble) exb++;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st, eb;
    idle();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;

    // Idle RUN.
    for (int i = 0; i < 4; i++) tick();
    settle();
    check("idle_pc_write", 32'(pc_write), 32'd1);
    check("idle_pc_sel", 32'(pc_sel), 32'd0);
    check("idle_stalls", {if_id_stall, id_ex_stall, id_ex_bubble, ex_mem_bubble}, 32'd0);
    check("idle_counters", {stall_cycles, flush_count}, 32'd0);

    // Load-use, then no hazard when the source is not read.
    ex_valid = 1; ex_mem_read = 1; ex_rd = 3; id_valid = 1; id_rs = 3; id_uses_rs = 1;
    settle();
    check("lu_ctl", {pc_write, if_id_stall, id_ex_bubble}, 32'b011);
    tick();
    idle();
    settle();
    check("lu_stall_cycles", 32'(stall_cycles), 32'd1);
    check("lu_released", 32'(pc_write), 32'd1);
    ex_valid = 1; ex_mem_read = 1; ex_rd = 3; id_valid = 1; id_rs = 3; id_uses_rs = 0;
    settle();
    check("lu_unused_rs", 32'(pc_write), 32'd1);
    tick();

    // Branch together with multi-cycle: branch wins.
    do_reset();
    ex_valid = 1; ex_branch_taken = 1; ex_mc = 1; ex_mc_len = 5;
    settle();
    check("br_mc_ctl", {pc_write, pc_sel, if_id_flush, id_ex_bubble, if_id_stall}, 32'b11110);
    tick();
    idle();
    settle();
    check("br_no_busy", 32'(pc_write), 32'd1);
    check("br_flush_count", 32'(flush_count), 32'd1);
    tick();

    // Multi-cycle boundaries.
    do_reset();
    mc_run(2, st, eb);
    check("mc2_stalls", 32'(st), 32'd1);
    do_reset();
    mc_run(15, st, eb);
    check("mc15_stalls", 32'(st), 32'd14);
    check("mc15_exb", 32'(eb), 32'd14);
    check("mc15_stall_cycles", 32'(stall_cycles), 32'd14);
    mc_run(0, st, eb);
    check("mc0_stalls", 32'(st), 32'd0);
    mc_run(1, st, eb);
    check("mc1_stalls", 32'(st), 32'd0);

    // Reset in the middle of MC_BUSY.
    ex_valid = 1; ex_mc = 1; ex_mc_len = 9;
    tick(); idle(); tick();
    reset_n = 0;
    settle();
    check("rst_mid_mc", {pc_write, if_id_stall, ex_mem_bubble, 8'(stall_cycles)}, 32'd0);
    tick();
    reset_n = 1;
    settle();
    check("after_rst_mc", 32'(pc_write), 32'd1);

    // Halt, held indefinitely, branch ignored, reset recovers.
    id_valid = 1; id_halt = 1;
    settle();
    check("halt_entry", {pc_write, if_id_stall, id_ex_bubble, halted}, 32'b0110);
    tick();
    idle();
    for (int i = 0; i < 20; i++) begin
      ex_valid = (i % 3 == 0); ex_branch_taken = 1;
      settle();
      check("halted_hold", {pc_write, pc_sel, if_id_flush, halted}, 32'b0001);
      tick();
    end
    check("halt_stall_cycles", 32'(stall_cycles), 32'd1);
    check("halt_flush_count", 32'(flush_count), 32'd0);
    idle();
    reset_n = 0;
    settle();
    check("rst_in_halt", {pc_write, if_id_stall, halted}, 32'd0);
    tick();
    reset_n = 1;
    settle();
    check("run_after_halt", {pc_write, halted}, 32'b10);

    // Halt coinciding with load-use is deferred one cycle.
    ex_valid = 1; ex_mem_read = 1; ex_rd = 5; id_valid = 1; id_rt = 5; id_uses_rt = 1; id_halt = 1;
    tick();
    ex_valid = 0; ex_mem_read = 0;
    settle();
    check("halt_deferred", 32'(halted), 32'd0);
    tick();
    idle();
    settle();
    check("halt_after_lu", 32'(halted), 32'd1);
    do_reset();

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      reset_n         = ($urandom_range(0, 99) != 0);
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs           = REG_W'($urandom_range(0, 7));
      id_rt           = REG_W'($urandom_range(0, 7));
      id_uses_rs      = $urandom_range(0, 1) == 1;
      id_uses_rt      = $urandom_range(0, 1) == 1;
      id_halt         = ($urandom_range(0, 63) == 0);
      ex_valid        = ($urandom_range(0, 3) != 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_rd           = REG_W'($urandom_range(0, 7));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_mc           = ($urandom_range(0, 7) == 0);
      ex_mc_len       = MC_W'($urandom_range(0, 15));
      tick();
    end

    // Flush counter saturation.
    do_reset();
    ex_valid = 1; ex_branch_taken = 1;
    for (int i = 0; i < 260; i++) tick();
    idle();
    settle();
    check("flush_sat", 32'(flush_count), 32'hFF);

    // Stall counter saturation via back-to-back length-15 ops:
    // 4683 ops x 14 stalls = 65562 > 65535.
    do_reset();
    ex_valid = 1; ex_mc = 1; ex_mc_len = 15;
    for (int i = 0; i < 4683 * 15; i++) tick();
    idle();
    tick(); tick();
    settle();
    check("stall_sat", 32'(stall_cycles), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage 8-bit-PC / 9-bit-instruction core. It generates the PC write-enable, the PC source select, and the stall/flush/bubble controls for the IF/ID, ID/EX and EX/MEM registers. It resolves taken branches, load-use hazards, multi-cycle EX operations and HALT, and keeps two saturating performance counters.

## Interface
- REG_W, 3: register-specifier width.
- MC_W, 4: width of the multi-cycle length field.
- CLK  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs, id_rt  in  REG_W  ID source register specifiers.
- id_uses_rs, id_uses_rt  in  1  corresponding source is actually read.
- id_halt  in  1  ID instruction is HALT.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_W  EX destination register.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- ex_mc  in  1  EX instruction is multi-cycle.
- ex_mc_len  in  MC_W  total EX occupancy in cycles; 0 and 1 both mean single-cycle.
- pc_write  out  1  PC register load enable.
- pc_sel  out  1  0 = PC+1, 1 = branch target.
- if_id_stall, if_id_flush  out  1  to the IF/ID register (flush has priority there).
- id_ex_stall, id_ex_bubble  out  1  hold ID/EX / load NOP into ID/EX.
- ex_mem_bubble  out  1  load NOP into EX/MEM.
- halted  out  1  controller is in HALTED.
- stall_cycles  out  16  saturating count of frozen-PC cycles, excluding HALTED.
- flush_count  out  8  saturating count of taken-branch redirects.

## Operation
- States: RUN, MC_BUSY, HALTED. There is also a down-counter mc_cnt[MC_W-1:0].
- Control outputs are combinational from the state and inputs. The defaults in RUN are pc_write=1 with all other controls 0.
- While reset_n=0, all outputs are 0.
- RUN evaluates its events in the following priority order (highest first).
- 1. Branch: ex_valid & ex_branch_taken.
  - Outputs: pc_write=1, pc_sel=1, if_id_flush=1, id_ex_bubble=1.
  - Stays in RUN. Any ex_mc on the same instruction is ignored.
- 2. Multi-cycle: ex_valid & ex_mc & ex_mc_len≥2.
  - Outputs: pc_write=0, if_id_stall=1, id_ex_stall=1, ex_mem_bubble=1.
  - Loads mc_cnt=ex_mc_len-2 and goes to MC_BUSY.
- 3. Load-use: ex_valid & ex_mem_read & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - Outputs: pc_write=0, if_id_stall=1, id_ex_bubble=1.
  - Stays in RUN.
- 4. Halt: id_valid & id_halt.
  - Outputs: pc_write=0, if_id_stall=1, id_ex_bubble=1.
  - Goes to HALTED.
- MC_BUSY:
  - If mc_cnt≠0: assert the same outputs as the multi-cycle entry cycle and decrement mc_cnt.
  - If mc_cnt=0: assert the RUN defaults (release) and go to RUN.
  - In MC_BUSY, branch, load-use and halt inputs are ignored.
- HALTED:
  - Outputs: pc_write=0, if_id_stall=1, id_ex_bubble=1, halted=1.
  - Exits only via reset.
- stall_cycles increments when pc_write=0 and the state is not HALTED, including the halt-entry cycle. It saturates at 16'hFFFF.
- flush_count increments on each branch event and saturates at 8'hFF.

## Timing
- Reset values: state=RUN, mc_cnt=0, stall_cycles=0, flush_count=0, halted=0. All combinational outputs are 0 during reset.
- Reset is asynchronous. Asserting it mid-MC_BUSY or in HALTED returns to RUN immediately.
- Branch: zero-cycle decision latency. Redirect, flush and bubble all occur in the same cycle that EX reports taken; the branch penalty is 2 instructions.
- Load-use: exactly 1 stall cycle. The next cycle sees the bubble in EX, so the hazard clears.
- Multi-cycle of length L≥2: exactly L-1 stall cycles (1 in RUN plus L-2 in MC_BUSY), then 1 release cycle.
  - L=2 gives MC_BUSY entered with mc_cnt=0, which releases at once.
  - L=15 gives 14 stalls.
- A hazard is evaluated only if ex_valid / id_valid are asserted.
- Simultaneous events resolve strictly by the RUN priority order above.
- A halt that coincides with a load-use is deferred until the stall clears.
- The counters update on the rising edge after the qualifying cycle.

## Test plan
- Reset, then idle RUN with no hazards:
  - pc_write=1, pc_sel=0, all stalls 0, counters stay 0.
  - Assert reset_n=0 mid-run: all outputs 0 immediately.
- Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_uses_rs=1.
  - One cycle with pc_write=0, if_id_stall=1, id_ex_bubble=1.
  - stall_cycles=1. No stall when id_uses_rs=0.
- Branch and multi-cycle together: ex_branch_taken=1, ex_mc=1, ex_mc_len=5 in the same cycle.
  - Branch wins: pc_sel=1, if_id_flush=1, id_ex_bubble=1, no MC_BUSY.
  - flush_count=1.
- Multi-cycle boundaries:
  - ex_mc_len=2 gives 1 stall cycle.
  - ex_mc_len=15 gives 14 stall cycles with ex_mem_bubble=1, and stall_cycles=14.
  - ex_mc_len=0 and 1 give no stall.
- Halt: id_halt=1 with no hazard.
  - Next cycle halted=1 and pc_write=0, held indefinitely.
  - A branch input in HALTED is ignored.
  - reset_n pulse returns to RUN.
- Saturation: force 65540 stall cycles via back-to-back multi-cycle ops.
  - stall_cycles holds at 16'hFFFF.
  - 260 branches give flush_count=8'hFF.
